// File: rtl/mc_ctrl_pkg.sv
// Shared state, step-code and opcode definitions for the multi-cycle control sequencer.
package mc_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;

    // FETCH..WRITEBACK encodings equal their step codes; IDLE sits on an unused code
    // internally and is mapped back to 000 on the step output.
    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_IDLE   = 3'b101,
        S_TRAP   = 3'b111
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;

    typedef struct packed {
        logic legal;
        logic exec;
        logic mem;
        logic wb;
    } path_t;

    function automatic path_t decode_path(input logic [OPCODE_W-1:0] op);
        path_t p;
        p = '0;
        case (op)
            OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: p = '{legal: 1'b1, exec: 1'b1, mem: 1'b0, wb: 1'b1};
            OP_LW:         p = '{legal: 1'b1, exec: 1'b1, mem: 1'b1, wb: 1'b1};
            OP_SW:         p = '{legal: 1'b1, exec: 1'b1, mem: 1'b1, wb: 1'b0};
            OP_BEQ, OP_BNE: p = '{legal: 1'b1, exec: 1'b1, mem: 1'b0, wb: 1'b0};
            OP_J:          p = '{legal: 1'b1, exec: 1'b0, mem: 1'b0, wb: 1'b0};
            OP_JAL:        p = '{legal: 1'b1, exec: 1'b0, mem: 1'b0, wb: 1'b1};
            default:       p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [2:0] step_code(input state_e s);
        return (s == S_IDLE) ? 3'b000 : 3'(s);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles of one FETCH/MEMORY step and flags the last allowed one.
module mc_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW   = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
    localparam int unsigned LAST = (WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Asserted during the WAIT_LIMIT-th stalled cycle, so a stall never exceeds WAIT_LIMIT cycles.
    assign expired = (WAIT_LIMIT != 0) && (cnt_q == CW'(LAST));

endmodule

// File: rtl/mc_step_sequencer.sv
// Multi-cycle MIPS32 step sequencer driving a 3-to-8 active-low step decoder.
// Optional performance counters enabled by defining MC_STEP_PERF_EN.
module mc_step_sequencer
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic [2:0]          step,
    output logic                dec_e1,
    output logic                dec_ne2,
    output logic                dec_ne3,
    output logic                mem_req,
    output logic                instr_done,
    output logic                busy,
    output logic                illegal,
    output logic                timeout
`ifdef MC_STEP_PERF_EN
    ,
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instr_cnt
`endif
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [2:0]          step_q, step_d;
    logic                dec_e1_q, dec_e1_d;
    logic                dec_ne2_q, dec_ne2_d;
    logic                dec_ne3_q, dec_ne3_d;
    logic                mem_req_q, mem_req_d;
    logic                instr_done_q, instr_done_d;
    logic                busy_q, busy_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;

    path_t dec_path, op_path;
    logic  mem_state, waiting, active, last, expired;

    mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .inc     (waiting),
        .expired (expired)
    );

    always_comb begin
        dec_path  = decode_path(opcode);
        op_path   = decode_path(op_q);
        mem_state = (state_q == S_FETCH) || (state_q == S_MEM);
        waiting   = mem_state && !mem_ready;
        active    = (state_q != S_IDLE) && (state_q != S_TRAP);
        last      = 1'b0;
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        op_d      = (state_q == S_DECODE) ? opcode : op_q;

        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (!dec_path.legal) begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end else if (dec_path.exec) begin
                    state_d = S_EXEC;
                end else if (dec_path.wb) begin
                    state_d = S_WB;
                end else begin
                    last = 1'b1;
                end
            end
            S_EXEC: begin
                if (op_path.mem)     state_d = S_MEM;
                else if (op_path.wb) state_d = S_WB;
                else                 last    = 1'b1;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_path.wb) state_d = S_WB;
                    else            last    = 1'b1;
                end else if (expired) begin
                    state_d   = S_TRAP;
                    timeout_d = 1'b1;
                end
            end
            S_WB:    last = 1'b1;
            default: state_d = S_TRAP;
        endcase

        if (last)
            state_d = halt_req ? S_IDLE : S_FETCH;

        // Outputs register a view of the step executing this cycle, including its handshake result.
        step_d       = step_code(state_q);
        dec_e1_d     = active;
        dec_ne2_d    = !active;
        dec_ne3_d    = !active || waiting;
        mem_req_d    = mem_state;
        instr_done_d = last;
        busy_d       = active;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            step_q       <= 3'b000;
            dec_e1_q     <= 1'b0;
            dec_ne2_q    <= 1'b1;
            dec_ne3_q    <= 1'b1;
            mem_req_q    <= 1'b0;
            instr_done_q <= 1'b0;
            busy_q       <= 1'b0;
            illegal_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            step_q       <= step_d;
            dec_e1_q     <= dec_e1_d;
            dec_ne2_q    <= dec_ne2_d;
            dec_ne3_q    <= dec_ne3_d;
            mem_req_q    <= mem_req_d;
            instr_done_q <= instr_done_d;
            busy_q       <= busy_d;
            illegal_q    <= illegal_d;
            timeout_q    <= timeout_d;
        end
    end

    assign step       = step_q;
    assign dec_e1     = dec_e1_q;
    assign dec_ne2    = dec_ne2_q;
    assign dec_ne3    = dec_ne3_q;
    assign mem_req    = mem_req_q;
    assign instr_done = instr_done_q;
    assign busy       = busy_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;

`ifdef MC_STEP_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + {31'b0, busy_q};
        instr_cnt_d = instr_cnt_q + {31'b0, instr_done_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_step_sequencer.sv
// Scoreboard bench for mc_step_sequencer; the registered outputs after each edge show the step
// that ran in the cycle just ended, so expectations are queued with each cycle's stimulus.
module tb_mc_step_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, halt_req, mem_ready;
    logic [5:0]  opcode;
    logic [2:0]  step;
    logic        dec_e1, dec_ne2, dec_ne3, mem_req, instr_done, busy, illegal, timeout;
`ifdef MC_STEP_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct packed {
        logic [2:0] step;
        logic       e1, ne2, ne3, req, done, busy, ill, to;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mc_step_sequencer #(.WAIT_LIMIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .halt_req   (halt_req),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .step       (step),
        .dec_e1     (dec_e1),
        .dec_ne2    (dec_ne2),
        .dec_ne3    (dec_ne3),
        .mem_req    (mem_req),
        .instr_done (instr_done),
        .busy       (busy),
        .illegal    (illegal),
        .timeout    (timeout)
`ifdef MC_STEP_PERF_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // act: active (non-IDLE/TRAP) step; w: stalled on memory
    function automatic exp_t ev(input logic [2:0] s, input logic act, input logic w,
                                input logic req, input logic done,
                                input logic ill, input logic to);
        ev = '{step: s, e1: act, ne2: !act, ne3: !act || w, req: req,
               done: done, busy: act, ill: ill, to: to};
    endfunction

    task automatic cyc(input logic rst, input logic st, input logic hr, input logic mr,
                       input logic [5:0] op, input exp_t e);
        exp_t x;
        reset = rst; start = st; halt_req = hr; mem_ready = mr; opcode = op;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("step",    {29'b0, step}, {29'b0, x.step});
        check("enables", {29'b0, dec_e1, dec_ne2, dec_ne3}, {29'b0, x.e1, x.ne2, x.ne3});
        check("mem_req", {31'b0, mem_req},    {31'b0, x.req});
        check("done",    {31'b0, instr_done}, {31'b0, x.done});
        check("busy",    {31'b0, busy},       {31'b0, x.busy});
        check("illegal", {31'b0, illegal},    {31'b0, x.ill});
        check("timeout", {31'b0, timeout},    {31'b0, x.to});
    endtask

    exp_t RST, IDL;

    initial begin
        RST = ev(3'b000, 0, 0, 0, 0, 0, 0);
        IDL = RST;
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; opcode = '0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 6'h00, RST);

        // lw, memory always ready
        cyc(0, 1, 0, 1, 6'h00, IDL);
        cyc(0, 0, 0, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, 1, 6'h23, ev(3'b001, 1, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, ev(3'b010, 1, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, ev(3'b011, 1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, ev(3'b100, 1, 0, 0, 1, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));
        cyc(1, 0, 0, 0, 6'h00, RST);

        // sw with three stalled MEMORY cycles
        cyc(0, 1, 0, 0, 6'h00, IDL);
        cyc(0, 0, 0, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'h2B, ev(3'b001, 1, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'h00, ev(3'b010, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 6'h00, ev(3'b011, 1, 1, 1, 0, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, ev(3'b011, 1, 0, 1, 1, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));

        // jal then beq with halt in EXECUTE
        cyc(0, 0, 0, 0, 6'h03, ev(3'b001, 1, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'h00, ev(3'b100, 1, 0, 0, 1, 0, 0));
        cyc(0, 1, 1, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));
        cyc(0, 0, 1, 0, 6'h04, ev(3'b001, 1, 0, 0, 0, 0, 0));
        cyc(0, 0, 1, 0, 6'h00, ev(3'b010, 1, 0, 0, 1, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, IDL);
        cyc(0, 0, 0, 1, 6'h00, IDL);

        // illegal opcode traps; start ignored until reset
        cyc(0, 1, 0, 1, 6'h00, IDL);
        cyc(0, 0, 0, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, 1, 6'h3F, ev(3'b001, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 0, 1, 6'h23, ev(3'b111, 0, 0, 0, 0, 1, 0));
        cyc(1, 0, 0, 0, 6'h00, RST);

        // FETCH stall hits WAIT_LIMIT=4
        cyc(0, 1, 0, 0, 6'h00, IDL);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 6'h00, ev(3'b000, 1, 1, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'h00, ev(3'b000, 1, 1, 1, 0, 0, 1));
        cyc(0, 1, 0, 1, 6'h00, ev(3'b111, 0, 0, 0, 0, 0, 1));
        cyc(0, 1, 0, 1, 6'h00, ev(3'b111, 0, 0, 0, 0, 0, 1));
        cyc(1, 0, 0, 0, 6'h00, RST);

        // reset in the middle of EXECUTE
        cyc(0, 1, 0, 0, 6'h00, IDL);
        cyc(0, 0, 0, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, ev(3'b001, 1, 0, 0, 0, 0, 0));
        cyc(1, 0, 0, 1, 6'h00, RST);
        cyc(0, 0, 0, 1, 6'h00, IDL);

        // R-type, then j with halt: 6 busy cycles, 2 instructions
        cyc(1, 0, 0, 0, 6'h00, RST);
        cyc(0, 1, 0, 0, 6'h00, IDL);
        cyc(0, 0, 0, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'h00, ev(3'b001, 1, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'h00, ev(3'b010, 1, 0, 0, 0, 0, 0));
        cyc(0, 0, 0, 0, 6'h00, ev(3'b100, 1, 0, 0, 1, 0, 0));
        cyc(0, 0, 0, 1, 6'h00, ev(3'b000, 1, 0, 1, 0, 0, 0));
        cyc(0, 0, 1, 0, 6'h02, ev(3'b001, 1, 0, 0, 1, 0, 0));
        cyc(0, 0, 0, 0, 6'h00, IDL);
        cyc(0, 0, 0, 0, 6'h00, IDL);
`ifdef MC_STEP_PERF_EN
        check("cycle_cnt", cycle_cnt, 32'd6);
        check("instr_cnt", instr_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
